led_ctrl: RTL and testbench
===========================

# led_ctrl

Parametrised LED driver that replaces direct switch-to-LED wiring on the lab board. Each switch input passes through a two-flop synchroniser and a shared debouncer. The resulting stable vector drives a WIDTH-bit LED bank in one of four display modes: pass-through, blink, rotating marquee and free-running binary counter. The block sits between the board switch/LED pins and the top level, clocked by the board oscillator.

## Interface
- WIDTH, 8: number of switches and LEDs.
- DB_CYCLES, 500000: cycles a changed switch vector must hold before it is accepted; must be at least 2.
- TICK_DIV, 5000000: clock cycles per display tick (blink, marquee and counter rate); must be at least 2.
- clk  input  1  board clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- switch  input  WIDTH  raw switch levels; asynchronous and bouncy.
- mode  input  2  display mode: 00 pass, 01 blink, 10 marquee, 11 counter. Asynchronous and quasi-static.
- led  output  WIDTH  registered LED drive; bit i lights LED i.

## Operation
- Synchronisers: switch and mode each pass through two flops. The synchronised outputs are s and mode_s. A further register, s_d, holds s delayed by one cycle.
- Debouncer: db_cnt (width clog2(DB_CYCLES)) and register stable. Each edge, evaluated in priority order:
  - s != s_d: db_cnt <= 0.
  - else s == stable: db_cnt <= 0.
  - else db_cnt == DB_CYCLES-1: stable <= s, db_cnt <= 0.
  - else db_cnt <= db_cnt+1.
  - All bits share one counter, so a change on any bit restarts acceptance of the whole vector.
- Prescaler: pre_cnt runs freely from 0 to TICK_DIV-1 and then wraps.
  - tick = 1 for the single cycle in which pre_cnt == TICK_DIV-1.
  - The prescaler is never cleared by mode changes.
- Mode entry: mode_q <= mode_s on every edge; entry = (mode_s != mode_q).
- Blink: phase toggles on every tick and runs in all modes.
- Marquee register pat:
  - On entry into 10: pat <= stable, or 1 if stable == 0.
  - Otherwise, in mode 10 on tick: pat rotates left by one; the MSB moves to bit 0.
  - Entry takes priority over a coincident tick.
- Counter register ctr:
  - On entry into 11: ctr <= 0.
  - Otherwise, in mode 11 on tick: ctr <= ctr+1, wrapping from 2^WIDTH-1 to 0.
  - Entry takes priority over a coincident tick.
- Output register, driven by the current mode_s:
  - 00: led <= stable.
  - 01: led <= phase ? stable : 0.
  - 10: led <= pat.
  - 11: led <= ctr.
- Changes to stable while in marquee mode do not reload pat; only mode entry does.

## Timing
- Reset values: led 0; stable, s, s_d, db_cnt, pre_cnt, phase, pat, ctr all 0; mode_q and mode_s 00. led goes 0 immediately on rst_n low, without waiting for clk.
- Reset released with the mode pin at 10 or 11 is an entry event once mode_s settles (2 edges).
- Switch latency: number the first edge that samples a new, steady switch value as edge 1.
  - stable updates on edge DB_CYCLES+3.
  - led updates on edge DB_CYCLES+4 (pass mode).
  - Any change in s before acceptance restarts the count.
- Mode latency: mode_s changes on edge 2; the entry load happens on edge 3; led shows the new mode's value on edge 4.
- Tick-driven updates: pat, ctr and phase change on the edge where tick = 1; led reflects the change one edge later.
- Reset asserted mid-debounce or mid-mode discards all state; nothing is retained.

## Test plan
All scenarios use WIDTH=8, DB_CYCLES=4, TICK_DIV=3.
- Reset: hold rst_n low, switch=0xFF, mode=00 → led=0x00 asynchronously; release rst_n → led=0xFF first on edge 8 after release, 0x00 on edges 1-7.
- Pass latency: mode 00, step switch 0x00→0xA5 → led=0x00 through edge 7, led=0xA5 from edge 8 on.
- Bounce rejection: mode 00, switch toggles 0x01/0x00 every 2 cycles for 20 cycles, then holds 0x01 → led stays 0x00 throughout the toggling; led=0x01 exactly 8 edges after the final change.
- Marquee:
  - stable=0x81, mode→10 → led=0x81, then 0x03, 0x06, 0x0C, each held 3 cycles.
  - stable=0x00, mode→10 → led=0x01, 0x02, … 0x80, then back to 0x01.
- Counter: mode→11 → led=0x00, 0x01, 0x02…, stepping every 3 cycles; after 256 ticks led wraps 0xFF→0x00.
- Blink and mid-run reset:
  - mode 01, stable=0x3C → led alternates 0x00/0x3C, each level held 3 cycles.
  - Pull rst_n low between clock edges → led=0x00 immediately.
  - After release, the blink sequence restarts from the reset state.

Source files
------------

// File: rtl/led_ctrl.sv
// -----------------------------------------------------------------------------
// led_ctrl
//
// LED driver that sits between the board switch/LED pins and the top level.
// Every switch passes through a two-flop synchroniser and a shared debouncer.
// The accepted (stable) switch vector drives the LED bank in one of four
// display modes selected by the quasi-static mode pins:
//   00 pass     : led = stable
//   01 blink    : led = stable gated by a free-running phase bit
//   10 marquee  : rotating pattern loaded from stable on mode entry
//   11 counter  : free-running binary counter cleared on mode entry
// Blink, marquee and counter all advance on a shared prescaler tick.
//
// Parameters
//   WIDTH      number of switches / LEDs (at least 2 so the marquee can rotate)
//   DB_CYCLES  cycles a changed switch vector must hold before acceptance (>= 2)
//   TICK_DIV   clock cycles per display tick (>= 2)
//
// Ports
//   clk     in   1      board clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   switch  in   WIDTH  raw switch levels (asynchronous, bouncy)
//   mode    in   2      display mode select (asynchronous, quasi-static)
//   led     out  WIDTH  registered LED drive, bit i lights LED i
// -----------------------------------------------------------------------------
module led_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 500000,
  parameter int TICK_DIV  = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switch,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led
);

  typedef enum logic [1:0] {
    MODE_PASS    = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_MARQUEE = 2'b10,
    MODE_COUNTER = 2'b11
  } mode_e;

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int PCW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [PCW-1:0] PRE_LAST = PCW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] switch_m;   // first (metastable) stage
  logic [WIDTH-1:0] s;          // synchronised switches
  logic [WIDTH-1:0] s_d;        // s delayed one cycle, used to spot bounce
  logic [1:0]       mode_m;     // first (metastable) stage
  mode_e            mode_s;     // synchronised mode
  mode_e            mode_q;     // mode_s delayed one cycle, for entry detect

  // NOTE: every register uses <= so all flops sample pre-edge values together;
  // a blocking = here would let s_d see the new s and collapse the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_m <= '0;
      s        <= '0;
      s_d      <= '0;
      mode_m   <= 2'b00;
      mode_s   <= MODE_PASS;
      mode_q   <= MODE_PASS;
    end else begin
      switch_m <= switch;
      s        <= switch_m;
      s_d      <= s;
      mode_m   <= mode;
      mode_s   <= mode_e'(mode_m);
      mode_q   <= mode_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer: one counter shared by all bits. Any movement of s restarts the
  // count, and a vector equal to the accepted one keeps the counter idle.
  // ---------------------------------------------------------------------------
  logic [DBW-1:0]   db_cnt, db_cnt_nxt;
  logic [WIDTH-1:0] stable, stable_nxt;

  // NOTE: each always_comb assigns every output a default first, so no path
  // through the if/else chain can leave a value unassigned and infer a latch.
  always_comb begin
    db_cnt_nxt = db_cnt;
    stable_nxt = stable;
    if (s != s_d) begin
      db_cnt_nxt = '0;
    end else if (s == stable) begin
      db_cnt_nxt = '0;
    end else if (db_cnt == DB_LAST) begin
      stable_nxt = s;
      db_cnt_nxt = '0;
    end else begin
      db_cnt_nxt = db_cnt + DBW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      stable <= '0;
    end else begin
      db_cnt <= db_cnt_nxt;
      stable <= stable_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler: free-running, never cleared by mode changes, so display rate
  // stays constant regardless of how often the user flips the mode pins.
  // ---------------------------------------------------------------------------
  logic [PCW-1:0] pre_cnt, pre_cnt_nxt;
  logic           tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_comb begin
    pre_cnt_nxt = pre_cnt + PCW'(1);
    if (tick) begin
      pre_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Display state: blink phase, marquee pattern and counter.
  // ---------------------------------------------------------------------------
  logic             entry;
  logic             phase, phase_nxt;
  logic [WIDTH-1:0] pat, pat_nxt;
  logic [WIDTH-1:0] ctr, ctr_nxt;

  // Mode entry is seen one cycle after mode_s moves; this also covers a reset
  // release with the mode pins already at marquee or counter.
  assign entry = (mode_s != mode_q);

  always_comb begin
    // Phase runs in every mode so blink timing is independent of mode history.
    phase_nxt = phase ^ tick;

    pat_nxt = pat;
    if (mode_s == MODE_MARQUEE) begin
      if (entry) begin
        // An all-dark pattern would rotate invisibly; seed a single LED.
        pat_nxt = (stable == '0) ? ONE_HOT0 : stable;
      end else if (tick) begin
        pat_nxt = {pat[WIDTH-2:0], pat[WIDTH-1]};
      end
    end

    ctr_nxt = ctr;
    if (mode_s == MODE_COUNTER) begin
      if (entry) begin
        ctr_nxt = '0;
      end else if (tick) begin
        ctr_nxt = ctr + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      pat   <= '0;
      ctr   <= '0;
    end else begin
      phase <= phase_nxt;
      pat   <= pat_nxt;
      ctr   <= ctr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register, selected by the current synchronised mode.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] led_nxt;

  always_comb begin
    led_nxt = '0;
    unique case (mode_s)
      MODE_PASS:    led_nxt = stable;
      MODE_BLINK:   led_nxt = phase ? stable : '0;
      MODE_MARQUEE: led_nxt = pat;
      MODE_COUNTER: led_nxt = ctr;
      default:      led_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_ctrl
//
// Scoreboard bench for led_ctrl with WIDTH=8, DB_CYCLES=4, TICK_DIV=3.
// The stimulus process pushes (cycle, expected led, name) entries into a
// queue; a monitor process on the falling edge pops and compares every entry
// whose cycle has been reached. Asynchronous reset behaviour is checked
// directly between clock edges.
// -----------------------------------------------------------------------------
module tb_led_ctrl;

  localparam int W  = 8;
  localparam int DB = 4;
  localparam int TD = 3;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b1;
  logic [W-1:0] switch = 8'hFF;
  logic [1:0]   mode   = 2'b00;
  logic [W-1:0] led;

  led_ctrl #(
    .WIDTH    (W),
    .DB_CYCLES(DB),
    .TICK_DIV (TD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .switch(switch),
    .mode  (mode),
    .led   (led)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int rel    = 0;   // cycle count at the most recent reset release

  int           q_at[$];
  logic [W-1:0] q_val[$];
  string        q_name[$];

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: led=%h expected %h", name, got, want);
    end
  endtask

  task automatic expect_at(input int at, input logic [W-1:0] val,
                           input string tag);
    q_at.push_back(at);
    q_val.push_back(val);
    q_name.push_back($sformatf("%s@%0d", tag, at - rel));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Advance until the last edge was a prescaler tick edge.
  task automatic align();
    while (((cyc - rel) % TD) != 0) step(1);
  endtask

  // Blink output after edge c, given reset release at r and a settled value.
  function automatic logic [W-1:0] blink_exp(input int c, input int r,
                                             input logic [W-1:0] st);
    return ((((c - 1 - r) / TD) % 2) == 1) ? st : 8'h00;
  endfunction

  // Monitor: compares the scoreboard head once its cycle is reached.
  always @(negedge clk) begin
    while (q_at.size() > 0 && q_at[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s: not sampled, now cycle %0d", q_name[0], cyc);
      void'(q_at.pop_front());
      void'(q_val.pop_front());
      void'(q_name.pop_front());
    end
    while (q_at.size() > 0 && q_at[0] == cyc) begin
      check(q_name[0], led, q_val[0]);
      void'(q_at.pop_front());
      void'(q_val.pop_front());
      void'(q_name.pop_front());
    end
  end

  initial begin
    int k;
    int m;
    logic [W-1:0] mq1 [4];
    mq1[0] = 8'h81; mq1[1] = 8'h03; mq1[2] = 8'h06; mq1[3] = 8'h0C;

    // Reset: async clear, then switches seen 8 edges after release.
    #1 rst_n = 1'b0;
    #1 check("reset_async", led, 8'h00);
    step(3);
    rst_n = 1'b1;
    rel   = cyc;
    for (int j = 1; j <= 7; j++) expect_at(rel + j, 8'h00, "reset_dark");
    expect_at(rel + 8, 8'hFF, "reset_ff");
    expect_at(rel + 9, 8'hFF, "reset_ff");
    step(12);

    // Pass latency 0x00 -> 0xA5.
    switch = 8'h00;
    step(10);
    k = cyc;
    switch = 8'hA5;
    for (int j = 1; j <= 7; j++) expect_at(k + j, 8'h00, "pass_old");
    expect_at(k + 8, 8'hA5, "pass_new");
    expect_at(k + 9, 8'hA5, "pass_new");
    step(10);

    // Bounce rejection.
    switch = 8'h00;
    step(10);
    k = cyc;
    for (int j = 1; j <= 27; j++) expect_at(k + j, 8'h00, "bounce_dark");
    expect_at(k + 28, 8'h01, "bounce_accept");
    for (int i = 0; i < 10; i++) begin
      switch = (i % 2 == 0) ? 8'h01 : 8'h00;
      step(2);
    end
    switch = 8'h01;
    step(30);

    // Marquee seeded from stable = 0x81.
    switch = 8'h81;
    step(10);
    align();
    m = cyc;
    mode = 2'b10;
    for (int j = 0; j < 4; j++)
      for (int d = 0; d < 3; d++) expect_at(m + 4 + 3 * j + d, mq1[j], "marq81");
    step(16);

    // Marquee seeded from stable = 0x00 (single lit LED, full lap).
    mode   = 2'b00;
    switch = 8'h00;
    step(12);
    align();
    m = cyc;
    mode = 2'b10;
    for (int j = 0; j < 9; j++)
      for (int d = 0; d < 3; d++)
        expect_at(m + 4 + 3 * j + d, 8'(1 << (j % 8)), "marq00");
    step(33);

    // Counter, through the 0xFF -> 0x00 wrap.
    align();
    m = cyc;
    mode = 2'b11;
    for (int j = 0; j <= 256; j++)
      for (int d = 0; d < 3; d++)
        expect_at(m + 4 + 3 * j + d, 8'(j % 256), "counter");
    step(4 + 3 * 257 + 2);

    // Blink with stable = 0x3C.
    k = cyc;
    switch = 8'h3C;
    mode   = 2'b01;
    for (int c = k + 9; c <= k + 20; c++)
      expect_at(c, blink_exp(c, rel, 8'h3C), "blink");
    step(22);

    // Mid-run reset between edges while the LEDs are lit.
    for (int i = 0; i < 10 && blink_exp(cyc, rel, 8'h3C) != 8'h3C; i++) step(1);
    check("blink_lit_before_reset", led, 8'h3C);
    #3 rst_n = 1'b0;
    #1 check("reset_mid_async", led, 8'h00);
    step(2);
    rst_n = 1'b1;
    rel   = cyc;
    for (int j = 1; j <= 7; j++) expect_at(rel + j, 8'h00, "rst_blink_dark");
    for (int c = rel + 8; c <= rel + 21; c++)
      expect_at(c, blink_exp(c, rel, 8'h3C), "rst_blink");
    step(24);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 100 && q_at.size() > 0; i++) step(1);
    while (q_at.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never reached", q_name[0]);
      void'(q_at.pop_front());
      void'(q_val.pop_front());
      void'(q_name.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
